// File: rtl/vending_pkg.sv
// vending_pkg: coin encodings, coin values and value lookup shared by the vending datapath.
// Exports coin_t (2-bit coin code), CIRCLE/TRIANGLE/PENTAGON_VALUE and coin_value().
package vending_pkg;
  typedef enum logic [1:0] {COIN_NONE, COIN_CIRCLE, COIN_TRIANGLE, COIN_PENTAGON} coin_t;
  localparam logic [2:0] CIRCLE_VALUE = 3'd1;
  localparam logic [2:0] TRIANGLE_VALUE = 3'd3;
  localparam logic [2:0] PENTAGON_VALUE = 3'd5;
  function automatic logic [2:0] coin_value(coin_t c);
    return c == COIN_CIRCLE ? CIRCLE_VALUE :
           c == COIN_TRIANGLE ? TRIANGLE_VALUE :
           c == COIN_PENTAGON ? PENTAGON_VALUE : 3'd0;
  endfunction
endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: signal bundle between the coin chute / FSM side and the coin acceptor.
// Sensors, drop and clear_overflow flow into the acceptor; coin, pending_count, overflow
// (and total_value when COIN_ACCEPTOR_STATS_EN is defined) flow out.
// master: chute/FSM side. slave: coin_acceptor.
interface coin_acceptor_if #(parameter int FIFO_DEPTH = 4);
  import vending_pkg::*;
  logic sensor_circle;
  logic sensor_triangle;
  logic sensor_pentagon;
  logic drop;
  logic clear_overflow;
  coin_t coin;
  logic [$clog2(FIFO_DEPTH):0] pending_count;
  logic overflow;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] total_value;
  modport master(output sensor_circle, sensor_triangle, sensor_pentagon, drop, clear_overflow,
                 input coin, pending_count, overflow, total_value);
  modport slave(input sensor_circle, sensor_triangle, sensor_pentagon, drop, clear_overflow,
                output coin, pending_count, overflow, total_value);
`else
  modport master(output sensor_circle, sensor_triangle, sensor_pentagon, drop, clear_overflow,
                 input coin, pending_count, overflow);
  modport slave(input sensor_circle, sensor_triangle, sensor_pentagon, drop, clear_overflow,
                output coin, pending_count, overflow);
`endif
endinterface

// File: rtl/coin_debouncer.sv
// coin_debouncer: 2-flop synchroniser plus debounce filter for one raw chute sensor.
// Ports: clock, reset (async, active-high), raw (asynchronous sensor),
// rise (one-cycle pulse, combinational, on the edge the debounced level flips 0->1).
module coin_debouncer #(parameter int DEBOUNCE_CYCLES = 4) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q;
  logic s2_q;
  logic stable_q;
  logic stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic flip;
  always_comb begin
    // The count only ever reaches DEBOUNCE_CYCLES on the flipping edge, so it is
    // stored one short and the flip fires when a disagreeing sample meets LAST.
    flip = s2_q != stable_q && cnt_q == LAST;
    cnt_d = s2_q == stable_q || flip ? '0 : cnt_q + 1'b1;
    stable_d = stable_q ^ flip;
    rise = flip && !stable_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces three coin sensors, queues coin events and issues them to the FSM.
// Ports: clock, reset (async, active-high), bus (coin_acceptor_if.slave): sensors, drop,
// clear_overflow in; coin, pending_count, overflow out. Defining COIN_ACCEPTOR_STATS_EN adds
// bus.total_value, a saturating sum of issued coin values.
module coin_acceptor import vending_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic clock,
  input logic reset,
  coin_acceptor_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  logic [2:0] raw;
  logic [2:0] ev;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] grant;
  logic [2:0] lost;
  logic [AW:0] wr_q;
  logic [AW:0] wr_d;
  logic [AW:0] rd_q;
  logic [AW:0] rd_d;
  logic [AW:0] count;
  coin_t mem_q [FIFO_DEPTH];
  coin_t mem_d [FIFO_DEPTH];
  coin_t push_coin;
  coin_t head;
  logic gap_q;
  logic gap_d;
  logic overflow_q;
  logic overflow_d;
  logic full;
  logic empty;
  logic issue;
  assign raw = {bus.sensor_pentagon, bus.sensor_triangle, bus.sensor_circle};
  for (genvar i = 0; i < 3; i++) begin : g_deb
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock(clock),
      .reset(reset),
      .raw(raw[i]),
      .rise(ev[i])
    );
  end
  always_comb begin
    count = wr_q - rd_q;
    full = count == DEPTH_C;
    empty = count == '0;
    grant = full ? 3'b000 : pend_q[2] ? 3'b100 : pend_q[1] ? 3'b010 : pend_q[0] ? 3'b001 : 3'b000;
    push_coin = grant[2] ? COIN_PENTAGON : grant[1] ? COIN_TRIANGLE : COIN_CIRCLE;
    // A new event on a bit that is being granted this edge re-arms it instead of being lost.
    lost = ev & pend_q & ~grant;
    pend_d = (pend_q & ~grant) | ev;
    head = mem_q[rd_q[AW-1:0]];
    // gap_q forces an idle cycle after each coin so the FSM's drop cycle never swallows one.
    issue = !empty && !bus.drop && !gap_q;
    gap_d = issue;
    rd_d = rd_q + {{AW{1'b0}}, issue};
    wr_d = wr_q + {{AW{1'b0}}, |grant};
    mem_d = mem_q;
    if (|grant) mem_d[wr_q[AW-1:0]] = push_coin;
    overflow_d = |lost || (overflow_q && !bus.clear_overflow);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pend_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      gap_q <= 1'b0;
      overflow_q <= 1'b0;
      mem_q <= '{default: COIN_NONE};
    end else begin
      pend_q <= pend_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      gap_q <= gap_d;
      overflow_q <= overflow_d;
      mem_q <= mem_d;
    end
  assign bus.coin = issue ? head : COIN_NONE;
  assign bus.pending_count = count;
  assign bus.overflow = overflow_q;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] total_q;
  logic [7:0] total_d;
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, total_q} + {6'd0, issue ? coin_value(head) : 3'd0};
    total_d = sum[8] ? 8'hff : sum[7:0];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) total_q <= '0;
    else total_q <= total_d;
  assign bus.total_value = total_q;
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized scoreboard bench for coin_acceptor against a rule-level model.
module tb_coin_acceptor;
  import vending_pkg::*;
  localparam int D = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total_checks = 0;
  int passed = 0;
  int exp_q[$];
  bit [15:0] m_hist [3];
  bit [2:0] m_stable = '0;
  bit [2:0] m_pend = '0;
  int m_fifo[$];
  bit m_gap = 1'b0;
  bit m_ov = 1'b0;
  int m_total = 0;
  int value_of[4] = '{0, 1, 3, 5};
  coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus();
  coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask
  // Reference model: a level changes once the last D synchronised samples (raw delayed two
  // edges) all disagree with it; coins queue by priority and issue with one idle cycle after.
  always @(posedge clk or posedge rst) begin
    bit [2:0] raw;
    bit [2:0] ev;
    bit [2:0] grant;
    bit issue;
    bit win;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_stable = '0;
      m_pend = '0;
      m_fifo.delete();
      m_gap = 1'b0;
      m_ov = 1'b0;
      m_total = 0;
    end else begin
      raw = {bus.sensor_pentagon, bus.sensor_triangle, bus.sensor_circle};
      ev = '0;
      for (int i = 0; i < 3; i++) begin
        win = 1'b1;
        for (int k = 1; k <= D; k++) if (m_hist[i][k] == m_stable[i]) win = 1'b0;
        ev[i] = win && !m_stable[i];
        if (win) m_stable[i] = !m_stable[i];
        m_hist[i] = {m_hist[i][14:0], raw[i]};
      end
      grant = '0;
      if (m_fifo.size() < DEPTH) begin
        for (int i = 0; i < 3; i++) if (m_pend[i]) grant = 3'b001 << i;
      end
      issue = m_fifo.size() > 0 && !bus.drop && !m_gap;
      if (issue) begin
        m_total = m_total + value_of[m_fifo[0]];
        if (m_total > 255) m_total = 255;
        void'(m_fifo.pop_front());
      end
      for (int i = 0; i < 3; i++) if (grant[i]) m_fifo.push_back(i + 1);
      if (|(ev & m_pend & ~grant)) m_ov = 1'b1;
      else if (bus.clear_overflow) m_ov = 1'b0;
      m_pend = (m_pend & ~grant) | ev;
      m_gap = issue;
    end
  end
  task automatic cyc(input bit [2:0] s, input bit d, input bit clr);
    @(negedge clk);
    bus.sensor_circle = s[0];
    bus.sensor_triangle = s[1];
    bus.sensor_pentagon = s[2];
    bus.drop = d;
    bus.clear_overflow = clr;
    #1;
    if (!rst && m_fifo.size() > 0 && !d && !m_gap) exp_q.push_back(m_fifo[0]);
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.coin != COIN_NONE) begin
        if (exp_q.size() == 0) check("unexpected_coin", int'(bus.coin), 0);
        else check("coin", int'(bus.coin), exp_q.pop_front());
      end
      check("pending_count", int'(bus.pending_count), m_fifo.size());
      check("overflow", int'(bus.overflow), int'(m_ov));
`ifdef COIN_ACCEPTOR_STATS_EN
      check("total_value", int'(bus.total_value), m_total);
`endif
    end
  end
  initial begin
    int run[3];
    bit [2:0] s;
    bus.sensor_circle = 1'b0;
    bus.sensor_triangle = 1'b0;
    bus.sensor_pentagon = 1'b0;
    bus.drop = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_coin", int'(bus.coin), 0);
    check("reset_pending", int'(bus.pending_count), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    rst = 1'b0;
    repeat (10) cyc(3'b001, 0, 0);
    repeat (10) cyc(3'b000, 0, 0);
    repeat (3) cyc(3'b010, 0, 0);
    repeat (10) cyc(3'b000, 0, 0);
    repeat (8) cyc(3'b111, 0, 0);
    repeat (15) cyc(3'b000, 0, 0);
    repeat (8) cyc(3'b110, 1, 0);
    repeat (5) cyc(3'b000, 1, 0);
    repeat (12) cyc(3'b000, 0, 0);
    for (int p = 0; p < 5; p++) begin
      repeat (6) cyc(3'b111, 1, 0);
      repeat (6) cyc(3'b000, 1, 0);
    end
    cyc(3'b000, 1, 1);
    repeat (3) cyc(3'b000, 1, 0);
    repeat (30) cyc(3'b000, 0, 0);
    run = '{0, 0, 0};
    s = '0;
    repeat (800) begin
      for (int i = 0; i < 3; i++) begin
        if (run[i] == 0) begin
          s[i] = 1'($urandom_range(0, 1));
          run[i] = $urandom_range(1, 8);
        end
        run[i]--;
      end
      cyc(s, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    repeat (30) cyc(3'b000, 0, 0);
    repeat (8) cyc(3'b011, 1, 0);
    repeat (4) cyc(3'b100, 1, 0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset_coin", int'(bus.coin), 0);
    check("async_reset_pending", int'(bus.pending_count), 0);
    check("async_reset_overflow", int'(bus.overflow), 0);
`ifdef COIN_ACCEPTOR_STATS_EN
    check("async_reset_total", int'(bus.total_value), 0);
`endif
    exp_q.delete();
    repeat (2) cyc(3'b100, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) cyc(3'b100, 0, 0);
    repeat (20) cyc(3'b000, 0, 0);
    check("leftover_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end
endmodule
